core_io_bridge: RTL and testbench
=================================

Name: core_io_bridge

Overview:
Sits directly downstream of the 16-bit core's memory port (24-bit Address, WriteData, WriteEnable, ReadData).
- Decodes Address[23:16] into banks: RAM bank passes through to external data/instruction RAM; IO bank maps a small register file.
- IO registers: TX FIFO toward a peripheral, RX holding register, status, 32-bit cycle counter.
- Read path is combinational, because the core consumes ReadData in the same cycle it drives Address. Write side effects occur at posedge clk.

Parameters:
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RAM_BANK, 8'h00, Address[23:16] value selecting external RAM
IO_BANK, 8'h01, Address[23:16] value selecting IO registers

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
Address  in  24  core address; [23:16] bank, [15:0] offset
WriteData  in  16  core write data
WriteEnable  in  1  core write strobe, one write per cycle high
ReadData  out  16  combinational read data to core
ram_addr  out  16  Address[15:0] passthrough
ram_wdata  out  16  WriteData passthrough
ram_we  out  1  WriteEnable && bank==RAM_BANK && !rst
ram_rdata  in  16  RAM read data (combinational)
tx_data  out  16  FIFO head; 0 when empty
tx_valid  out  1  FIFO not empty
tx_ready  in  1  peripheral accepts head
rx_data  in  16  incoming word
rx_valid  in  1  incoming word valid
rx_ready  out  1  !rx_full && !rst

Behaviour:
- IO offset map (Address[15:0], IO bank):
  - 0x0000 TXDATA: write pushes WriteData; read returns 0.
  - 0x0001 STATUS: read {11'b0, rx_full, tx_ovf, tx_full, tx_empty, 1'b1}.
  - 0x0002 RXDATA: read returns rx_hold; no read side effect.
  - 0x0003 RXACK: write (any data) clears rx_full.
  - 0x0004 CYC_LO: read returns cycle[15:0].
  - 0x0005 CYC_HI: read returns cycle[31:16].
  - 0x0006 OVFCLR: write clears tx_ovf.
  - Other offsets: read 0, write ignored.
- ReadData:
  - RAM bank -> ram_rdata.
  - IO bank -> mapped register.
  - Any other bank -> 16'h0000.
  - Reads never alter state.
- Write event: sampled at posedge when WriteEnable=1; each high cycle is exactly one write.
- TX FIFO:
  - Read/write pointers are log2(TX_DEPTH)+1 bits wide.
  - Pop when tx_valid && tx_ready.
  - Push accepted if not full OR pop in the same cycle. With simultaneous push and pop, count is unchanged.
  - Push when full with no pop is dropped and sets sticky tx_ovf.
  - A push to an empty FIFO gives tx_valid=1 and tx_data valid in the next cycle (latency 1).
  - Pointers wrap modulo 2*TX_DEPTH.
- RX:
  - When rx_valid && rx_ready, capture rx_data into rx_hold and set rx_full.
  - While rx_full, no capture occurs; rx_valid/rx_data are held by the peripheral.
  - RXACK clears rx_full; the earliest next capture is the following cycle.
  - RXACK while empty is a no-op.
- cycle: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0. CYC_LO and CYC_HI are separate reads with no snapshot; software handles the carry.
- OVFCLR and an overflowing push in the same cycle: set wins, tx_ovf stays 1.
- Reset (synchronous, active-high), takes effect at the next posedge:
  - Pointers=0, tx_ovf=0, rx_full=0, rx_hold=0, cycle=0.
  - Outputs: tx_valid=0, tx_data=0, rx_ready=0 during rst, ram_we=0 during rst.
  - Reset mid-transfer discards FIFO contents and any pending rx word. Writes in a reset cycle are ignored.
- No state machine beyond FIFO/flag registers; all state updates occur on posedge clk only.

Decomposition:
- Package core_io_pkg holds:
  - Bank constants (RAM_BANK_DEF, IO_BANK_DEF).
  - Offset constants (OFF_TXDATA..OFF_OVFCLR).
  - STATUS bit indices.
- Sub-module io_tx_fifo(clk, rst, push, wdata, pop, rdata, empty, full, accept) owns storage and pointers. The top level owns decode, RX, counter and flags.

Test Plan:
- Reset, then read IO 0x0001 -> ReadData=16'h0003 (tx_empty=1, bit0=1); tx_valid=0; rx_ready=1.
- With tx_ready=0, write 0xA5A5 to IO 0x0000, followed by 8 more words -> tx_valid=1 and tx_data=0xA5A5 one cycle after the first write. After 8 pushes STATUS=0x0005 (tx_full); the 9th push sets tx_ovf (STATUS=0x000D). OVFCLR -> 0x0005. Then with tx_ready=1, the 8 words drain in order, one per cycle.
- FIFO full, simultaneous push 0x1234 and pop -> push accepted, tx_ovf stays 0, 0x1234 appears last.
- rx_valid=1, rx_data=0xBEEF -> next cycle rx_ready=0 and RXDATA read=0xBEEF. A new rx_data=0xCAFE is held off. RXACK write -> next cycle 0xCAFE is captured.
- Read 0x00_0010 with ram_rdata=0x4321 -> ReadData=0x4321. Write at bank 0 -> ram_we=1. Write at bank 0x02 -> ram_we=0, no state change, ReadData=0.
- Force cycle=0xFFFF_FFFE, run 3 cycles -> CYC_HI=0x0000, CYC_LO=0x0001. Assert rst mid-drain -> tx_valid=0 next cycle and STATUS=0x0003.

Source files
------------

// File: rtl/core_io_pkg.sv
// core_io_pkg: shared bank, offset and status-bit constants for the core IO bridge
package core_io_pkg;
  localparam logic [7:0] RAM_BANK_DEF = 8'h00;
  localparam logic [7:0] IO_BANK_DEF = 8'h01;
  localparam logic [15:0] OFF_TXDATA = 16'h0000;
  localparam logic [15:0] OFF_STATUS = 16'h0001;
  localparam logic [15:0] OFF_RXDATA = 16'h0002;
  localparam logic [15:0] OFF_RXACK = 16'h0003;
  localparam logic [15:0] OFF_CYC_LO = 16'h0004;
  localparam logic [15:0] OFF_CYC_HI = 16'h0005;
  localparam logic [15:0] OFF_OVFCLR = 16'h0006;
  localparam int ST_ONE = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_FULL = 2;
  localparam int ST_TX_OVF = 3;
  localparam int ST_RX_FULL = 4;
endpackage

// File: rtl/io_tx_fifo.sv
// io_tx_fifo: transmit FIFO with extra-MSB pointers; a push into a full FIFO is accepted only alongside a pop
module io_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] wdata,
  input  logic        pop,
  output logic [15:0] rdata,
  output logic        empty,
  output logic        full,
  output logic        accept
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr;
  logic [15:0] mem [DEPTH];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign accept = push && (!full || pop);
  assign rdata = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
  // storage write; the slot being popped is freed in the same edge so a full push+pop is safe
  always_ff @(posedge clk)
    if (!rst && accept) mem[wr_ptr[AW-1:0]] <= wdata;
  // pointer advance, wrapping modulo 2*DEPTH through the extra MSB
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
endmodule

// File: rtl/core_io_bridge.sv
// core_io_bridge: bank decode between the core memory port, external RAM and a small IO register file
module core_io_bridge
  import core_io_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter logic [7:0] RAM_BANK = RAM_BANK_DEF,
  parameter logic [7:0] IO_BANK = IO_BANK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] Address,
  input  logic [15:0] WriteData,
  input  logic        WriteEnable,
  output logic [15:0] ReadData,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  input  logic [15:0] ram_rdata,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);
  logic [31:0] cycle;
  logic [15:0] rx_hold, status, io_rdata;
  logic tx_ovf, rx_full, tx_empty, tx_full, accept;
  logic [15:0] offset;
  logic ram_sel, io_sel, io_wr, push, pop;
  assign offset = Address[15:0];
  assign ram_sel = Address[23:16] == RAM_BANK;
  assign io_sel = Address[23:16] == IO_BANK;
  assign io_wr = WriteEnable && io_sel;
  assign push = io_wr && offset == OFF_TXDATA;
  assign pop = tx_valid && tx_ready;
  assign tx_valid = !tx_empty;
  assign ram_addr = offset;
  assign ram_wdata = WriteData;
  assign ram_we = WriteEnable && ram_sel && !rst;
  assign rx_ready = !rx_full && !rst;
  io_tx_fifo #(.DEPTH(TX_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .wdata(WriteData), .pop(pop),
    .rdata(tx_data), .empty(tx_empty), .full(tx_full), .accept(accept)
  );
  // combinational read mux; the core consumes ReadData in the address cycle
  always_comb begin
    status = '0;
    status[ST_ONE] = 1'b1;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_OVF] = tx_ovf;
    status[ST_RX_FULL] = rx_full;
    case (offset)
      OFF_STATUS: io_rdata = status;
      OFF_RXDATA: io_rdata = rx_hold;
      OFF_CYC_LO: io_rdata = cycle[15:0];
      OFF_CYC_HI: io_rdata = cycle[31:16];
      default:    io_rdata = 16'h0000;
    endcase
    ReadData = ram_sel ? ram_rdata : io_sel ? io_rdata : 16'h0000;
  end
  // cycle counter, sticky overflow (set beats clear) and RX holding register
  always_ff @(posedge clk)
    if (rst) begin
      cycle <= '0;
      tx_ovf <= 1'b0;
      rx_full <= 1'b0;
      rx_hold <= '0;
    end else begin
      cycle <= cycle + 1'b1;
      if (push && !accept) tx_ovf <= 1'b1;
      else if (io_wr && offset == OFF_OVFCLR) tx_ovf <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_hold <= rx_data;
        rx_full <= 1'b1;
      end else if (io_wr && offset == OFF_RXACK) rx_full <= 1'b0;
    end
endmodule

// File: tb/tb_core_io_bridge.sv
// tb_core_io_bridge: directed self-checking bench for the core IO bridge
module tb_core_io_bridge;
  logic clk = 1'b0, rst;
  logic [23:0] Address;
  logic [15:0] WriteData, ReadData, ram_addr, ram_wdata, ram_rdata, tx_data, rx_data;
  logic WriteEnable, ram_we, tx_valid, tx_ready, rx_valid, rx_ready;
  int total = 0, bad = 0;
  logic [15:0] r;
  logic [15:0] exp_q [$];
  localparam logic [23:0] IO = 24'h010000;
  core_io_bridge dut (
    .clk(clk), .rst(rst), .Address(Address), .WriteData(WriteData), .WriteEnable(WriteEnable),
    .ReadData(ReadData), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic wr(input logic [23:0] a, input logic [15:0] d);
    @(negedge clk);
    Address = a;
    WriteData = d;
    WriteEnable = 1'b1;
    @(negedge clk);
    WriteEnable = 1'b0;
  endtask
  task automatic rd(input logic [23:0] a, output logic [15:0] d);
    Address = a;
    #1;
    d = ReadData;
  endtask
  initial begin
    rst = 1'b1; Address = 24'h0; WriteData = 16'h0; WriteEnable = 1'b1;
    ram_rdata = 16'h0; tx_ready = 1'b0; rx_data = 16'h0; rx_valid = 1'b0;
    @(negedge clk);
    chk("ram_we_in_rst", ram_we, 0);
    chk("rx_ready_in_rst", rx_ready, 0);
    Address = IO; WriteData = 16'h7777;
    @(negedge clk);
    WriteEnable = 1'b0; rst = 1'b0;
    rd(IO | 24'h1, r); chk("status_reset", r, 16'h0003);
    chk("tx_valid_reset", tx_valid, 0);
    chk("tx_data_reset", tx_data, 0);
    chk("rx_ready_reset", rx_ready, 1);
    rd(IO | 24'h4, r); chk("cyc_lo_reset", r, 16'h0000);
    wr(IO, 16'hA5A5); exp_q.push_back(16'hA5A5);
    chk("tx_valid_lat1", tx_valid, 1);
    chk("tx_data_first", tx_data, 16'hA5A5);
    for (int i = 1; i < 8; i++) begin
      wr(IO, 16'h1000 + 16'(i)); exp_q.push_back(16'h1000 + 16'(i));
    end
    rd(IO | 24'h1, r); chk("status_full", r, 16'h0005);
    wr(IO, 16'hDEAD);
    rd(IO | 24'h1, r); chk("status_ovf", r, 16'h000D);
    wr(IO | 24'h6, 16'h0);
    rd(IO | 24'h1, r); chk("status_ovfclr", r, 16'h0005);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain1_%0d", i), tx_data, exp_q.pop_front());
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_valid_drained", tx_valid, 0);
    chk("tx_data_drained", tx_data, 0);
    for (int i = 0; i < 8; i++) begin
      wr(IO, 16'h2000 + 16'(i)); exp_q.push_back(16'h2000 + 16'(i));
    end
    @(negedge clk);
    Address = IO; WriteData = 16'h1234; WriteEnable = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    WriteEnable = 1'b0; tx_ready = 1'b0;
    void'(exp_q.pop_front()); exp_q.push_back(16'h1234);
    rd(IO | 24'h1, r); chk("status_pushpop_full", r, 16'h0005);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain2_%0d", i), tx_data, exp_q.pop_front());
      @(negedge clk);
    end
    tx_ready = 1'b0;
    chk("tx_valid_drained2", tx_valid, 0);
    rx_valid = 1'b1; rx_data = 16'hBEEF;
    @(negedge clk);
    chk("rx_ready_full", rx_ready, 0);
    rd(IO | 24'h2, r); chk("rxdata_beef", r, 16'hBEEF);
    rd(IO | 24'h1, r); chk("status_rx_full", r, 16'h0013);
    rx_data = 16'hCAFE;
    @(negedge clk);
    rd(IO | 24'h2, r); chk("rxdata_held", r, 16'hBEEF);
    wr(IO | 24'h3, 16'h0);
    chk("rx_ready_after_ack", rx_ready, 1);
    rd(IO | 24'h2, r); chk("rxdata_not_yet", r, 16'hBEEF);
    @(negedge clk);
    rd(IO | 24'h2, r); chk("rxdata_cafe", r, 16'hCAFE);
    chk("rx_ready_cafe", rx_ready, 0);
    rx_valid = 1'b0;
    wr(IO | 24'h3, 16'h0);
    wr(IO | 24'h3, 16'h0);
    rd(IO | 24'h1, r); chk("status_ack_empty", r, 16'h0003);
    ram_rdata = 16'h4321;
    rd(24'h000010, r); chk("ram_read", r, 16'h4321);
    chk("ram_addr", ram_addr, 16'h0010);
    WriteData = 16'h5555; WriteEnable = 1'b1; #1;
    chk("ram_we_bank0", ram_we, 1);
    chk("ram_wdata", ram_wdata, 16'h5555);
    @(negedge clk);
    WriteEnable = 1'b0;
    wr(24'h020000, 16'h9999);
    rd(24'h020000, r); chk("bank2_read", r, 16'h0000);
    Address = 24'h020000; WriteEnable = 1'b1; #1;
    chk("ram_we_bank2", ram_we, 0);
    WriteEnable = 1'b0;
    rd(IO | 24'h1, r); chk("status_bank2_write", r, 16'h0003);
    rd(IO | 24'h7, r); chk("io_unmapped", r, 16'h0000);
    rd(IO, r); chk("txdata_read", r, 16'h0000);
    @(negedge clk);
    force dut.cycle = 32'hFFFF_FFFE;
    #1 release dut.cycle;
    repeat (3) @(negedge clk);
    rd(IO | 24'h5, r); chk("cyc_hi_wrap", r, 16'h0000);
    rd(IO | 24'h4, r); chk("cyc_lo_wrap", r, 16'h0001);
    for (int i = 0; i < 3; i++) wr(IO, 16'h3000 + 16'(i));
    tx_ready = 1'b1;
    @(negedge clk);
    chk("drain3_second", tx_data, 16'h3001);
    rst = 1'b1;
    @(negedge clk);
    chk("tx_valid_rst", tx_valid, 0);
    chk("tx_data_rst", tx_data, 0);
    chk("rx_ready_rst", rx_ready, 0);
    rst = 1'b0; tx_ready = 1'b0;
    rd(IO | 24'h1, r); chk("status_after_rst", r, 16'h0003);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
